// File: rtl/cp0_exc_ctrl_pkg.sv
// CP0 register numbers, exception codes and Status bit positions shared by the
// exception controller and its bench.
package cp0_exc_ctrl_pkg;

   localparam logic [4:0] RD_COUNT   = 5'd9;
   localparam logic [4:0] RD_COMPARE = 5'd11;
   localparam logic [4:0] RD_STATUS  = 5'd28;
   localparam logic [4:0] RD_CAUSE   = 5'd29;
   localparam logic [4:0] RD_EPC     = 5'd30;

   localparam int ST_IE     = 0;
   localparam int ST_EXL    = 1;
   localparam int ST_IM_INT = 8;
   localparam int ST_IM_SYS = 9;
   localparam int ST_IM_RI  = 10;
   localparam int ST_IM_OV  = 11;
   localparam int ST_IM_TMR = 12;

   typedef enum logic [4:0] {
      EXC_INT = 5'd0,
      EXC_SYS = 5'd8,
      EXC_RI  = 5'd10,
      EXC_OV  = 5'd12
   } exc_code_e;

   // RUN <-> HANDLER is exactly Status.EXL
   typedef enum logic {
      RUN     = 1'b0,
      HANDLER = 1'b1
   } cp0_state_e;

endpackage

// File: rtl/cp0_exc_ctrl_intr_sync.sv
// Two-flop synchronizer for the asynchronous interrupt line plus a rising-edge
// detector; o_rise is a one-cycle pulse per synchronized 0->1 transition.
module intr_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic r_s1, r_s2, r_s3;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Status/Cause/EPC, source arbitration,
// eret return and mfc0/mtc0. Define CP0_TIMER_EN to add Count/Compare timer.
module cp0_exc_ctrl
   import cp0_exc_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VEC    = 32'h0000_0038,
   parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Clrn,
   input  logic [31:0] Pc,
   input  logic        Ovf,
   input  logic        Unimpl,
   input  logic        Sys,
   input  logic        Intr,
   input  logic        Mfc0,
   input  logic        Mtc0,
   input  logic        Eret,
   input  logic [4:0]  Rd,
   input  logic [31:0] Wdata,
   output logic [31:0] Rdata,
   output logic        Exc,
   output logic        Redirect,
   output logic [31:0] RedirectPc,
   output logic        IntrAck
);

   // EXL lives in the state register, so it is excluded from this mask
`ifdef CP0_TIMER_EN
   localparam logic [31:0] ST_WMASK = 32'h0000_1F01;
`else
   localparam logic [31:0] ST_WMASK = 32'h0000_0F01;
`endif

   cp0_state_e  r_state, w_state_nxt;
   logic [31:0] r_status, r_epc, w_status_rd;
   logic [4:0]  r_cause;
   logic        r_pend, r_ack;
   logic        w_rise, w_tmr, w_ov, w_ri, w_sys, w_int, w_exc, w_int_take, w_eret_ok;
   exc_code_e   w_code;

   intr_sync u_intr_sync (
      .i_clk   (Clk),
      .i_rst_n (Clrn),
      .i_async (Intr),
      .o_rise  (w_rise)
   );

   assign w_eret_ok  = Eret & (r_state == HANDLER);
   assign w_ov       = Ovf & r_status[ST_IM_OV];
   assign w_ri       = (Unimpl | (Eret & (r_state == RUN))) & r_status[ST_IM_RI];
   assign w_sys      = Sys & r_status[ST_IM_SYS];
   assign w_int      = r_pend & r_status[ST_IE] & r_status[ST_IM_INT] & (r_state == RUN);
   assign w_exc      = w_ov | w_ri | w_sys | w_int | w_tmr;
   assign w_int_take = w_int & ~(w_ov | w_ri | w_sys);

   // timer interrupt shares ExcCode 0 with the external one
   always_comb begin
      w_code = EXC_INT;
      if (w_ov)       w_code = EXC_OV;
      else if (w_ri)  w_code = EXC_RI;
      else if (w_sys) w_code = EXC_SYS;
   end

   assign Exc        = w_exc;
   assign Redirect   = w_exc | w_eret_ok;
   assign RedirectPc = w_exc ? EXC_VEC : r_epc;
   assign IntrAck    = r_ack;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) r_state <= cp0_state_e'(STATUS_RST[ST_EXL]);
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_exc)
         w_state_nxt = HANDLER;
      else if (w_eret_ok)
         w_state_nxt = RUN;
      else if (Mtc0 && Rd == RD_STATUS)
         w_state_nxt = cp0_state_e'(Wdata[ST_EXL]);
   end

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         r_status <= STATUS_RST & ST_WMASK;
         r_cause  <= 5'd0;
         r_epc    <= 32'd0;
         r_pend   <= 1'b0;
         r_ack    <= 1'b0;
      end else begin
         r_ack <= w_int_take;
         if (w_rise)          r_pend <= 1'b1;
         else if (w_int_take) r_pend <= 1'b0;
         if (w_exc) begin
            r_cause <= w_code;
            if (r_state == RUN) r_epc <= Pc;
         end else if (Mtc0) begin
            case (Rd)
               RD_STATUS: r_status <= Wdata & ST_WMASK;
               RD_CAUSE:  r_cause  <= Wdata[6:2];
               RD_EPC:    r_epc    <= Wdata;
               default: ;
            endcase
         end
      end
   end

`ifdef CP0_TIMER_EN
   logic [31:0] r_count, r_compare;
   logic        r_tpend;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         r_count   <= 32'd0;
         r_compare <= 32'd0;
         r_tpend   <= 1'b0;
      end else begin
         r_count <= r_count + 32'd1;
         if (Mtc0 && !w_exc && Rd == RD_COUNT) r_count <= Wdata;
         if (Mtc0 && !w_exc && Rd == RD_COMPARE) begin
            r_compare <= Wdata;
            r_tpend   <= 1'b0;
         end else if (r_count == r_compare && r_compare != 32'd0) begin
            r_tpend <= 1'b1;
         end
      end
   end

   assign w_tmr = r_tpend & r_status[ST_IE] & r_status[ST_IM_TMR] & (r_state == RUN);
`else
   assign w_tmr = 1'b0;
`endif

   assign w_status_rd = r_status | {30'd0, r_state == HANDLER, 1'b0};

   always_comb begin
      Rdata = 32'd0;
      if (Mfc0) begin
         case (Rd)
            RD_STATUS:  Rdata = w_status_rd;
            RD_CAUSE:   Rdata = {25'd0, r_cause, 2'b00};
            RD_EPC:     Rdata = r_epc;
`ifdef CP0_TIMER_EN
            RD_COUNT:   Rdata = r_count;
            RD_COMPARE: Rdata = r_compare;
`endif
            default:    Rdata = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Table-driven check of cp0_exc_ctrl (default build) plus hand-written
// interrupt, eret and reset sequences.
module tb_cp0_exc_ctrl;

   logic        Clk = 1'b0, Clrn = 1'b0;
   logic [31:0] Pc, Wdata, Rdata, RedirectPc;
   logic        Ovf, Unimpl, Sys, Intr, Mfc0, Mtc0, Eret, Exc, Redirect, IntrAck;
   logic [4:0]  Rd;
   int          errs = 0, checks = 0;

   cp0_exc_ctrl dut (
      .Clk(Clk), .Clrn(Clrn), .Pc(Pc), .Ovf(Ovf), .Unimpl(Unimpl), .Sys(Sys),
      .Intr(Intr), .Mfc0(Mfc0), .Mtc0(Mtc0), .Eret(Eret), .Rd(Rd), .Wdata(Wdata),
      .Rdata(Rdata), .Exc(Exc), .Redirect(Redirect), .RedirectPc(RedirectPc),
      .IntrAck(IntrAck)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        ovf, unimpl, sys, eret, mtc0, mfc0;
      logic [4:0]  rd;
      logic [31:0] wdata, pc;
      logic        exc, red;
      logic [31:0] rpc, rdata;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic ovf, logic ri, logic sys, logic eret, logic mtc0,
                               logic mfc0, logic [4:0] rd, logic [31:0] wdata,
                               logic [31:0] pc, logic exc, logic red,
                               logic [31:0] rpc, logic [31:0] rdata);
      vec_t v;
      v.ovf = ovf; v.unimpl = ri; v.sys = sys; v.eret = eret; v.mtc0 = mtc0;
      v.mfc0 = mfc0; v.rd = rd; v.wdata = wdata; v.pc = pc;
      v.exc = exc; v.red = red; v.rpc = rpc; v.rdata = rdata;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      Pc = 32'h0; Ovf = 0; Unimpl = 0; Sys = 0; Mfc0 = 0; Mtc0 = 0; Eret = 0;
      Rd = 5'd0; Wdata = 32'h0;
   endtask

   // advance to the next negedge, leave inputs idle for the caller to set
   task automatic nxt();
      @(negedge Clk);
      idle();
   endtask

   task automatic rd_chk(input string nm, input logic [4:0] r, input logic [31:0] exp);
      nxt();
      Mfc0 = 1; Rd = r;
      #2 chk(nm, Rdata, exp);
   endtask

   initial begin
      idle();
      Intr = 0;
      #3;
      chk("rst Exc", {31'd0, Exc}, 0);
      chk("rst Redirect", {31'd0, Redirect}, 0);
      chk("rst RedirectPc", RedirectPc, 0);
      chk("rst IntrAck", {31'd0, IntrAck}, 0);
      @(negedge Clk); @(negedge Clk);
      Clrn = 1;

      //            ovf ri sys er mt mf  rd  wdata          pc      exc red rpc      rdata
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 28, 32'h0,         32'h0,  0, 0, 32'h0,   32'h0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 32'h0,         32'h8,  0, 0, 32'h0,   32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 29, 32'h0,         32'h0,  0, 0, 32'h0,   32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 30, 32'h0,         32'h0,  0, 0, 32'h0,   32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 28, 32'hF01,       32'h0,  0, 0, 32'h0,   32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 28, 32'h0,         32'h0,  0, 0, 32'h0,   32'hF01));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 32'h0,         32'h8,  1, 1, 32'h38,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 29, 32'h0,         32'h0,  0, 0, 32'h8,   32'h30));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 30, 32'h0,         32'h0,  0, 0, 32'h8,   32'h8));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 28, 32'h0,         32'h0,  0, 0, 32'h8,   32'hF03));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 32'h0,         32'h40, 1, 1, 32'h38,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 30, 32'h0,         32'h0,  0, 0, 32'h8,   32'h8));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 29, 32'h0,         32'h0,  0, 0, 32'h8,   32'h20));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 32'h0,         32'h44, 0, 1, 32'h8,   32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 28, 32'h0,         32'h0,  0, 0, 32'h8,   32'hF01));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 32'h0,         32'h50, 1, 1, 32'h38,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 29, 32'h0,         32'h0,  0, 0, 32'h50,  32'h28));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 29, 32'hFFFF_FFFF, 32'h0,  0, 0, 32'h50,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 29, 32'h0,         32'h0,  0, 0, 32'h50,  32'h7C));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 30, 32'h100,       32'h0,  0, 0, 32'h50,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 30, 32'h0,         32'h0,  0, 0, 32'h100, 32'h100));
      tbl.push_back(mk(1, 1, 1, 0, 1, 0, 28, 32'h0,         32'h70, 1, 1, 32'h38,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 29, 32'h0,         32'h0,  0, 0, 32'h100, 32'h30));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 28, 32'h0,         32'h0,  0, 0, 32'h100, 32'hF03));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0,  0, 32'h0,         32'h74, 1, 1, 32'h38,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 29, 32'h0,         32'h0,  0, 0, 32'h100, 32'h28));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  5, 32'h0,         32'h0,  0, 0, 32'h100, 32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 28, 32'h701,       32'h0,  0, 0, 32'h100, 32'h0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 32'h0,         32'h60, 0, 0, 32'h100, 32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 28, 32'h0,         32'h0,  0, 0, 32'h100, 32'h701));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 32'h0,         32'h64, 1, 1, 32'h38,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 30, 32'h0,         32'h0,  0, 0, 32'h64,  32'h64));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 29, 32'h0,         32'h0,  0, 0, 32'h64,  32'h28));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 28, 32'h301,       32'h0,  0, 0, 32'h64,  32'h0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 32'h0,         32'h68, 0, 0, 32'h64,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 28, 32'h0,         32'h0,  0, 0, 32'h64,  32'h301));

      foreach (tbl[i]) begin
         nxt();
         Ovf = tbl[i].ovf; Unimpl = tbl[i].unimpl; Sys = tbl[i].sys; Eret = tbl[i].eret;
         Mtc0 = tbl[i].mtc0; Mfc0 = tbl[i].mfc0; Rd = tbl[i].rd; Wdata = tbl[i].wdata;
         Pc = tbl[i].pc;
         #2;
         chk($sformatf("v%0d Exc", i), {31'd0, Exc}, {31'd0, tbl[i].exc});
         chk($sformatf("v%0d Redirect", i), {31'd0, Redirect}, {31'd0, tbl[i].red});
         chk($sformatf("v%0d RedirectPc", i), RedirectPc, tbl[i].rpc);
         chk($sformatf("v%0d Rdata", i), Rdata, tbl[i].rdata);
         chk($sformatf("v%0d IntrAck", i), {31'd0, IntrAck}, 0);
      end

      // external interrupt: IE|IM_INT, Intr rises, taken in the 3rd cycle
      nxt(); Mtc0 = 1; Rd = 5'd28; Wdata = 32'h101;
      nxt(); Intr = 1; Pc = 32'h80;
      #2 chk("int c0 Exc", {31'd0, Exc}, 0);
      for (int k = 1; k <= 2; k++) begin
         nxt(); Pc = 32'h80;
         #2 chk($sformatf("int c%0d Exc", k), {31'd0, Exc}, 0);
      end
      nxt(); Pc = 32'h80;
      #2;
      chk("int c3 Exc", {31'd0, Exc}, 1);
      chk("int c3 RedirectPc", RedirectPc, 32'h38);
      chk("int c3 IntrAck", {31'd0, IntrAck}, 0);
      nxt(); Mfc0 = 1; Rd = 5'd29;
      #2;
      chk("int ack pulse", {31'd0, IntrAck}, 1);
      chk("int Cause", Rdata, 32'h0);
      chk("int nested Exc", {31'd0, Exc}, 0);
      nxt(); Mfc0 = 1; Rd = 5'd30;
      #2;
      chk("int ack drop", {31'd0, IntrAck}, 0);
      chk("int EPC", Rdata, 32'h80);
      rd_chk("int Status", 5'd28, 32'h103);

      // eret with Intr still high but no new edge: pending was consumed
      nxt(); Eret = 1;
      #2;
      chk("eret1 Redirect", {31'd0, Redirect}, 1);
      chk("eret1 RedirectPc", RedirectPc, 32'h80);
      nxt();
      #2 chk("eret1 no reint", {31'd0, Exc}, 0);

      // new edge while in the handler is held, then taken right after eret
      nxt(); Mtc0 = 1; Rd = 5'd28; Wdata = 32'h103;
      Intr = 0;
      for (int k = 0; k < 3; k++) nxt();
      Intr = 1;
      for (int k = 0; k < 4; k++) begin
         nxt();
         #2 chk($sformatf("held c%0d Exc", k), {31'd0, Exc}, 0);
      end
      nxt(); Eret = 1;
      #2;
      chk("eret2 Exc", {31'd0, Exc}, 0);
      chk("eret2 Redirect", {31'd0, Redirect}, 1);
      chk("eret2 RedirectPc", RedirectPc, 32'h80);
      nxt(); Pc = 32'h90;
      #2;
      chk("held int Exc", {31'd0, Exc}, 1);
      chk("held int RedirectPc", RedirectPc, 32'h38);
      nxt(); Mfc0 = 1; Rd = 5'd30;
      #2;
      chk("held int ack", {31'd0, IntrAck}, 1);
      chk("held int EPC", Rdata, 32'h90);

      // reset in the handler
      nxt(); Clrn = 0; Mfc0 = 1; Rd = 5'd28;
      #2;
      chk("mid rst Exc", {31'd0, Exc}, 0);
      chk("mid rst Redirect", {31'd0, Redirect}, 0);
      chk("mid rst RedirectPc", RedirectPc, 0);
      chk("mid rst IntrAck", {31'd0, IntrAck}, 0);
      chk("mid rst Status", Rdata, 0);
      Intr = 0;
      nxt(); Clrn = 1;
      rd_chk("post rst Status", 5'd28, 32'h0);
      rd_chk("post rst Cause", 5'd29, 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
